// File: rtl/mdll_jm_pkg.sv
// Shared types and constants for the MDLL jitter-measurement sequencer.
// Holds the sequencer states, the default data widths and the config decode helpers.
package mdll_jm_pkg;

   localparam int JM_W = 20;
   localparam int LF_W = 13;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      MEAS,
      SETTLE,
      CAPTURE,
      DONE
   } jm_state_e;

   // A zero config field encodes the largest value the field can represent plus one.
   function automatic logic [6:0] ncycle_eff(input logic [5:0] v);
      return (v == 6'd0) ? 7'd64 : {1'b0, v};
   endfunction

   function automatic logic [4:0] nrun_eff(input logic [3:0] v);
      return (v == 4'd0) ? 5'd16 : {1'b0, v};
   endfunction

endpackage

// File: rtl/mdll_jm_acc.sv
// Result accumulator: running sum, min, max, last loop-filter value and capture count.
// The clear strobe resets the statistics but deliberately keeps the last lf snapshot.
module mdll_jm_acc
   import mdll_jm_pkg::*;
#(
   parameter int JM_W = mdll_jm_pkg::JM_W,
   parameter int LF_W = mdll_jm_pkg::LF_W
) (
   input  logic            clk,
   input  logic            rstb,
   input  logic            clr_i,
   input  logic            cap_i,
   input  logic [JM_W-1:0] jm_i,
   input  logic [LF_W-1:0] lf_i,
   output logic [JM_W+3:0] sum_o,
   output logic [JM_W-1:0] min_o,
   output logic [JM_W-1:0] max_o,
   output logic [LF_W-1:0] lf_o,
   output logic [4:0]      nrun_o
);

   logic [JM_W+3:0] sum_q;
   logic [JM_W-1:0] min_q;
   logic [JM_W-1:0] max_q;
   logic [LF_W-1:0] lf_q;
   logic [4:0]      nrun_q;

   // Strict compares so equal samples leave min/max untouched.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         sum_q  <= '0;
         min_q  <= '1;
         max_q  <= '0;
         lf_q   <= '0;
         nrun_q <= '0;
      end else if (clr_i) begin
         sum_q  <= '0;
         min_q  <= '1;
         max_q  <= '0;
         nrun_q <= '0;
      end else if (cap_i) begin
         sum_q  <= sum_q + {4'b0000, jm_i};
         if (jm_i < min_q) min_q <= jm_i;
         if (jm_i > max_q) max_q <= jm_i;
         lf_q   <= lf_i;
         nrun_q <= nrun_q + 5'd1;
      end
   end

   assign sum_o  = sum_q;
   assign min_o  = min_q;
   assign max_o  = max_q;
   assign lf_o   = lf_q;
   assign nrun_o = nrun_q;

endmodule

// File: rtl/mdll_jm_seq.sv
// Host-side sequencer for the MDLL jitter-measurement path: runs nrun JM windows,
// accumulates jm_out statistics and hands the result to the register bank.
module mdll_jm_seq
   import mdll_jm_pkg::*;
#(
   parameter int SETTLE_CYC = 4,
   parameter int CLR_CYC    = 2,
   parameter int JM_W       = mdll_jm_pkg::JM_W,
   parameter int LF_W       = mdll_jm_pkg::LF_W
) (
   input  logic            clk,
   input  logic            rstb,
   input  logic            start,
   input  logic            abort,
   input  logic [5:0]      cfg_ncycle,
   input  logic [3:0]      cfg_nrun,
   input  logic [JM_W-1:0] jm_out,
   input  logic [LF_W-1:0] lf_out,
   output logic            en_jm,
   output logic [5:0]      ncycle_jm,
   output logic            busy,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [JM_W+3:0] res_sum,
   output logic [JM_W-1:0] res_min,
   output logic [JM_W-1:0] res_max,
   output logic [LF_W-1:0] res_lf,
   output logic [4:0]      res_nrun
);

   jm_state_e  state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [5:0] ncycle_q, ncycle_d;
   logic [4:0] target_q, target_d;
   logic       en_q, en_d;
   logic       acc_clr, acc_cap;
   logic [4:0] acc_nrun;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ncycle_q <= '0;
         target_q <= '0;
         en_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ncycle_q <= ncycle_d;
         target_q <= target_d;
         en_q     <= en_d;
      end
   end

   // cnt_q counts down the remaining cycles of the timed phases; abort overrides everything.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ncycle_d = ncycle_q;
      target_d = target_q;
      acc_clr  = 1'b0;
      acc_cap  = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  ncycle_d = cfg_ncycle;
                  target_d = nrun_eff(cfg_nrun);
                  acc_clr  = 1'b1;
                  cnt_d    = 8'(CLR_CYC - 1);
                  state_d  = CLR;
               end
            end
            CLR: begin
               if (cnt_q == 8'd0) begin
                  cnt_d   = {1'b0, ncycle_eff(ncycle_q)} - 8'd1;
                  state_d = MEAS;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            MEAS: begin
               if (cnt_q == 8'd0) begin
                  cnt_d   = 8'(SETTLE_CYC - 1);
                  state_d = SETTLE;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            SETTLE: begin
               if (cnt_q == 8'd0) begin
                  state_d = CAPTURE;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            CAPTURE: begin
               acc_cap = 1'b1;
               if (acc_nrun + 5'd1 == target_q) begin
                  state_d = DONE;
               end else begin
                  cnt_d   = 8'(CLR_CYC - 1);
                  state_d = CLR;
               end
            end
            DONE: begin
               if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      en_d = (state_d == MEAS);
   end

   mdll_jm_acc #(
      .JM_W(JM_W),
      .LF_W(LF_W)
   ) u_acc (
      .clk   (clk),
      .rstb  (rstb),
      .clr_i (acc_clr),
      .cap_i (acc_cap),
      .jm_i  (jm_out),
      .lf_i  (lf_out),
      .sum_o (res_sum),
      .min_o (res_min),
      .max_o (res_max),
      .lf_o  (res_lf),
      .nrun_o(acc_nrun)
   );

   assign res_nrun  = acc_nrun;
   assign en_jm     = en_q;
   assign ncycle_jm = ncycle_q;
   assign busy      = (state_q != IDLE) && (state_q != DONE);
   assign res_valid = (state_q == DONE);

endmodule

// File: tb/tb_mdll_jm_seq.sv
// Self-checking bench for mdll_jm_seq: models the MDLL side (jm_out/lf_out per window)
// and compares each result against a scoreboard of expected values.
module tb_mdll_jm_seq;

   logic        clk = 1'b0;
   logic        rstb, start, abort, res_ready;
   logic [5:0]  cfg_ncycle;
   logic [3:0]  cfg_nrun;
   logic [19:0] jm_out;
   logic [12:0] lf_out;
   logic        en_jm, busy, res_valid;
   logic [5:0]  ncycle_jm;
   logic [23:0] res_sum;
   logic [19:0] res_min, res_max;
   logic [12:0] res_lf;
   logic [4:0]  res_nrun;

   typedef struct {
      logic [23:0] sum;
      logic [19:0] mn;
      logic [19:0] mx;
      logic [12:0] lf;
      logic [4:0]  nrun;
      int          lat;
   } exp_t;

   exp_t        sbQ[$];
   logic [19:0] jmQ[$];
   logic [12:0] lfQ[$];
   int          asserts = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   mdll_jm_seq dut (
      .clk(clk), .rstb(rstb), .start(start), .abort(abort),
      .cfg_ncycle(cfg_ncycle), .cfg_nrun(cfg_nrun),
      .jm_out(jm_out), .lf_out(lf_out),
      .en_jm(en_jm), .ncycle_jm(ncycle_jm), .busy(busy),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_min(res_min), .res_max(res_max),
      .res_lf(res_lf), .res_nrun(res_nrun)
   );

   // Builds the expected result from the samples the MDLL model will present.
   task automatic push_expected(input int ncyc, input int nrun, input logic [19:0] jv[$], input logic [12:0] lv[$]);
      exp_t e;
      int n, r;
      n = (ncyc == 0) ? 64 : ncyc;
      r = (nrun == 0) ? 16 : nrun;
      e.sum = '0; e.mn = '1; e.mx = '0; e.lf = '0;
      for (int i = 0; i < r; i++) begin
         e.sum = e.sum + {4'b0, jv[i]};
         if (jv[i] < e.mn) e.mn = jv[i];
         if (jv[i] > e.mx) e.mx = jv[i];
         e.lf = lv[i];
      end
      e.nrun = 5'(r);
      e.lat = 1 + r * (2 + n + 4 + 1);
      sbQ.push_back(e);
      jmQ = jv;
      lfQ = lv;
   endtask

   // Drives one sequence, acting as the MDLL: new jm/lf values appear when each window closes.
   task automatic do_sequence(input logic [5:0] ncyc, input logic [3:0] nrun,
                              output int lat, output int wins, output int badWin, output bit tmo);
      int n, cyc, hi;
      bit prevEn;
      n = (ncyc == 6'd0) ? 64 : int'(ncyc);
      lat = 0; wins = 0; badWin = 0; tmo = 1'b1; hi = 0; prevEn = 1'b0;
      @(negedge clk);
      cfg_ncycle = ncyc; cfg_nrun = nrun; start = 1'b1;
      @(negedge clk);
      start = 1'b0; cfg_ncycle = ~ncyc; cfg_nrun = ~nrun; cyc = 1;
      while (cyc < 5000) begin
         if (res_valid) begin
            lat = cyc; tmo = 1'b0;
            break;
         end
         if (en_jm) hi++;
         else if (prevEn) begin
            wins++;
            if (hi != n) badWin++;
            hi = 0;
            if (jmQ.size() > 0) jm_out = jmQ.pop_front();
            if (lfQ.size() > 0) lf_out = lfQ.pop_front();
         end
         prevEn = en_jm;
         start = (cyc == 4);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
   endtask

   task automatic applyStimulus_init();
      rstb = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
      cfg_ncycle = '0; cfg_nrun = '0; jm_out = '0; lf_out = '0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      asserts++;
      if (en_jm !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || ncycle_jm !== 6'd0) begin
         fails++; $display("[TB] FAIL reset_ctrl: en=%b busy=%b valid=%b ncyc=%0d, exp 0 0 0 0", en_jm, busy, res_valid, ncycle_jm);
      end
      asserts++;
      if (res_sum !== 24'd0 || res_min !== 20'hFFFFF || res_max !== 20'd0 || res_lf !== 13'd0 || res_nrun !== 5'd0) begin
         fails++; $display("[TB] FAIL reset_res: sum=%h min=%h max=%h lf=%h n=%0d, exp 0 fffff 0 0 0", res_sum, res_min, res_max, res_lf, res_nrun);
      end
      rstb = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      exp_t e;
      int lat, wins, bad;
      bit tmo;
      push_expected(8, 1, '{20'h00123}, '{13'h0042});
      do_sequence(6'd8, 4'd1, lat, wins, bad, tmo);
      e = sbQ.pop_front();
      asserts++; if (tmo) begin fails++; $display("[TB] FAIL single_timeout: res_valid not seen, exp within 5000 cycles"); end
      asserts++; if (lat != e.lat) begin fails++; $display("[TB] FAIL single_latency: got %0d exp %0d", lat, e.lat); end
      asserts++; if (wins != 1 || bad != 0) begin fails++; $display("[TB] FAIL single_windows: wins=%0d bad=%0d exp 1 0", wins, bad); end
      asserts++; if (ncycle_jm !== 6'd8) begin fails++; $display("[TB] FAIL single_ncycle_jm: got %0d exp 8", ncycle_jm); end
      asserts++;
      if (res_sum !== e.sum || res_min !== e.mn || res_max !== e.mx || res_nrun !== e.nrun || res_lf !== e.lf) begin
         fails++; $display("[TB] FAIL single_result: sum=%h min=%h max=%h lf=%h n=%0d exp %h %h %h %h %0d",
                           res_sum, res_min, res_max, res_lf, res_nrun, e.sum, e.mn, e.mx, e.lf, e.nrun);
      end
   endtask

   task automatic test_multi();
      exp_t e;
      int lat, wins, bad;
      bit tmo;
      push_expected(5, 3, '{20'd100, 20'd50, 20'd200}, '{13'h0100, 13'h0200, 13'h1ABC});
      do_sequence(6'd5, 4'd3, lat, wins, bad, tmo);
      e = sbQ.pop_front();
      asserts++; if (tmo || lat != e.lat) begin fails++; $display("[TB] FAIL multi_latency: got %0d (tmo=%0d) exp %0d", lat, tmo, e.lat); end
      asserts++; if (wins != 3 || bad != 0) begin fails++; $display("[TB] FAIL multi_windows: wins=%0d bad=%0d exp 3 0", wins, bad); end
      asserts++; if (res_sum !== e.sum) begin fails++; $display("[TB] FAIL multi_sum: got %0d exp %0d", res_sum, e.sum); end
      asserts++; if (res_min !== e.mn || res_max !== e.mx) begin fails++; $display("[TB] FAIL multi_minmax: got %0d/%0d exp %0d/%0d", res_min, res_max, e.mn, e.mx); end
      asserts++; if (res_lf !== e.lf || res_nrun !== e.nrun) begin fails++; $display("[TB] FAIL multi_lf_nrun: got %h/%0d exp %h/%0d", res_lf, res_nrun, e.lf, e.nrun); end
   endtask

   task automatic test_reset_mid_meas();
      int guard;
      @(negedge clk);
      cfg_ncycle = 6'd20; cfg_nrun = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!en_jm && guard < 50) begin @(negedge clk); guard++; end
      asserts++; if (!en_jm) begin fails++; $display("[TB] FAIL rstmeas_en_rise: en_jm=%b exp 1", en_jm); end
      repeat (5) @(negedge clk);
      rstb = 1'b0;
      #1;
      asserts++;
      if (en_jm !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || ncycle_jm !== 6'd0) begin
         fails++; $display("[TB] FAIL rstmeas_ctrl: en=%b busy=%b valid=%b ncyc=%0d exp 0 0 0 0", en_jm, busy, res_valid, ncycle_jm);
      end
      asserts++;
      if (res_sum !== 24'd0 || res_min !== 20'hFFFFF || res_max !== 20'd0 || res_lf !== 13'd0 || res_nrun !== 5'd0) begin
         fails++; $display("[TB] FAIL rstmeas_res: sum=%h min=%h max=%h lf=%h n=%0d exp 0 fffff 0 0 0", res_sum, res_min, res_max, res_lf, res_nrun);
      end
      @(negedge clk);
      rstb = 1'b1;
      repeat (4) @(negedge clk);
      asserts++; if (busy !== 1'b0 || en_jm !== 1'b0) begin fails++; $display("[TB] FAIL rstmeas_idle: busy=%b en=%b exp 0 0", busy, en_jm); end
   endtask

   task automatic test_max_cfg();
      exp_t e;
      int lat, wins, bad;
      bit tmo;
      logic [19:0] jv[$];
      logic [12:0] lv[$];
      for (int i = 0; i < 16; i++) begin jv.push_back(20'hFFFFF); lv.push_back(13'(i + 1)); end
      push_expected(0, 0, jv, lv);
      do_sequence(6'd0, 4'd0, lat, wins, bad, tmo);
      e = sbQ.pop_front();
      asserts++; if (tmo || lat != e.lat) begin fails++; $display("[TB] FAIL max_latency: got %0d (tmo=%0d) exp %0d", lat, tmo, e.lat); end
      asserts++; if (wins != 16 || bad != 0) begin fails++; $display("[TB] FAIL max_windows: wins=%0d bad=%0d exp 16 0", wins, bad); end
      asserts++; if (res_sum !== 24'hFFFFF0) begin fails++; $display("[TB] FAIL max_sum: got %h exp fffff0", res_sum); end
      asserts++;
      if (res_sum !== e.sum || res_min !== e.mn || res_max !== e.mx || res_nrun !== e.nrun || res_lf !== e.lf) begin
         fails++; $display("[TB] FAIL max_result: sum=%h min=%h max=%h lf=%h n=%0d exp %h %h %h %h %0d",
                           res_sum, res_min, res_max, res_lf, res_nrun, e.sum, e.mn, e.mx, e.lf, e.nrun);
      end
   endtask

   task automatic test_abort();
      int wins, cyc, sawValid;
      bit prevEn;
      jmQ = '{20'd10, 20'd20, 20'd30, 20'd40};
      wins = 0; prevEn = 1'b0; cyc = 0;
      @(negedge clk);
      cfg_ncycle = 6'd3; cfg_nrun = 4'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < 500 && wins < 2) begin
         if (!en_jm && prevEn) begin
            wins++;
            jm_out = jmQ.pop_front();
            if (wins == 2) abort = 1'b1;
         end
         prevEn = en_jm;
         if (wins < 2) begin @(negedge clk); cyc++; end
      end
      asserts++; if (wins != 2) begin fails++; $display("[TB] FAIL abort_reach: windows=%0d exp 2", wins); end
      @(negedge clk);
      abort = 1'b0;
      asserts++;
      if (en_jm !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL abort_idle: en=%b busy=%b valid=%b exp 0 0 0", en_jm, busy, res_valid);
      end
      asserts++; if (res_nrun !== 5'd1 || res_sum !== 24'd10) begin fails++; $display("[TB] FAIL abort_partial: n=%0d sum=%0d exp 1 10", res_nrun, res_sum); end
      sawValid = 0;
      repeat (60) begin @(negedge clk); if (res_valid || busy) sawValid++; end
      asserts++; if (sawValid != 0) begin fails++; $display("[TB] FAIL abort_quiet: active cycles=%0d exp 0", sawValid); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int lat, wins, bad;
      bit tmo;
      res_ready = 1'b0;
      push_expected(3, 2, '{20'd7, 20'd3}, '{13'h0055, 13'h0066});
      do_sequence(6'd3, 4'd2, lat, wins, bad, tmo);
      e = sbQ.pop_front();
      asserts++; if (tmo || lat != e.lat) begin fails++; $display("[TB] FAIL bp_latency: got %0d (tmo=%0d) exp %0d", lat, tmo, e.lat); end
      for (int i = 0; i < 10; i++) begin
         start = (i == 3);
         asserts++;
         if (res_valid !== 1'b1 || busy !== 1'b0 || en_jm !== 1'b0 || res_sum !== e.sum || res_min !== e.mn ||
             res_max !== e.mx || res_lf !== e.lf || res_nrun !== e.nrun) begin
            fails++; $display("[TB] FAIL bp_hold[%0d]: valid=%b busy=%b sum=%0d min=%0d max=%0d lf=%h n=%0d exp 1 0 %0d %0d %0d %h %0d",
                              i, res_valid, busy, res_sum, res_min, res_max, res_lf, res_nrun, e.sum, e.mn, e.mx, e.lf, e.nrun);
         end
         @(negedge clk);
      end
      start = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      asserts++; if (res_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL bp_release: valid=%b busy=%b exp 0 0", res_valid, busy); end
      push_expected(2, 1, '{20'h00042}, '{13'h0777});
      do_sequence(6'd2, 4'd1, lat, wins, bad, tmo);
      e = sbQ.pop_front();
      asserts++; if (tmo || lat != e.lat) begin fails++; $display("[TB] FAIL b2b_latency: got %0d (tmo=%0d) exp %0d", lat, tmo, e.lat); end
      asserts++;
      if (res_sum !== e.sum || res_min !== e.mn || res_max !== e.mx || res_lf !== e.lf || res_nrun !== e.nrun) begin
         fails++; $display("[TB] FAIL b2b_result: sum=%h min=%h max=%h lf=%h n=%0d exp %h %h %h %h %0d",
                           res_sum, res_min, res_max, res_lf, res_nrun, e.sum, e.mn, e.mx, e.lf, e.nrun);
      end
   endtask

   initial begin
      applyStimulus_init();
      test_reset();
      test_single();
      test_multi();
      test_reset_mid_meas();
      test_max_cfg();
      test_abort();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
